// File: rtl/adbg_ahb3_slave_if.sv
// AHB3-Lite bus bundle between the debug unit's bus master and its RAM responder.
interface adbg_ahb3_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  HSEL;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [1:0]            HTRANS;
    logic                  HMASTLOCK;
    logic                  HREADY;
    logic                  HREADYOUT;
    logic                  HRESP;

    // HREADY really comes from the interconnect; the master side drives it here.
    modport master (
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/adbg_ahb3_slave.sv
// AHB3-Lite RAM responder: word-addressed RAM, fixed wait states on OKAY
// transfers, two-cycle ERROR response, read-after-write forwarding.
module adbg_ahb3_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    adbg_ahb3_slave_if.slave  bus
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int LB = $clog2(NB);
    localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t                state, state_nxt;
    logic [3:0]            cnt;
    logic                  ready_o, resp_o;

    logic                  accept, acc_err, oob, bad_size, misalign, load_rd, fwd;
    logic [ADDR_WIDTH-1:0] word_full;
    logic [IW-1:0]         acc_idx;
    logic [NB-1:0]         acc_mask;
    logic [DATA_WIDTH-1:0] ram_acc, acc_word, wr_bits;

    logic                  dp_vld, dp_write;
    logic [IW-1:0]         dp_idx;
    logic [NB-1:0]         dp_mask;
    logic                  wr_commit;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Sideband fields carry no meaning for a plain RAM target.
    logic unused_sideband;
    assign unused_sideband = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.HTRANS[0]};

    // Byte lanes touched by a transfer of 2**size bytes starting at lane 'low'.
    function automatic logic [NB-1:0] lane_mask(input logic [2:0] size, input logic [LB-1:0] low);
        logic [NB-1:0] m;
        int lo, n;
        m  = '0;
        lo = int'(low);
        n  = 1 << size;
        for (int i = 0; i < NB; i++)
            if (i >= lo && i < lo + n) m[i] = 1'b1;
        return m;
    endfunction

    // Expand a byte-lane mask to a bit mask.
    function automatic logic [DATA_WIDTH-1:0] bit_mask(input logic [NB-1:0] m);
        logic [DATA_WIDTH-1:0] b;
        for (int i = 0; i < NB; i++) b[8*i +: 8] = {8{m[i]}};
        return b;
    endfunction

    // Address phase decode. Acceptance also needs our own ready so a stray
    // HREADY during WAIT/ERR1 cannot overwrite the in-flight transfer.
    assign accept    = bus.HSEL & bus.HREADY & bus.HTRANS[1] & ready_o;
    assign word_full = bus.HADDR >> LB;
    assign oob       = word_full >= ADDR_WIDTH'(MEM_DEPTH);
    assign bad_size  = bus.HSIZE > 3'(LB);
    assign misalign  = |(bus.HADDR[7:0] & ((8'd1 << bus.HSIZE) - 8'd1));
    assign acc_err   = oob | bad_size | misalign;
    assign acc_idx   = bus.HADDR[LB +: IW];
    assign acc_mask  = lane_mask(bus.HSIZE, bus.HADDR[LB-1:0]);
    assign load_rd   = accept & ~acc_err & ~bus.HWRITE;

    // A write's final data-phase cycle is always spent in IDLE.
    assign wr_commit = dp_vld & dp_write & (state == S_IDLE);
    assign wr_bits   = bit_mask(dp_mask);

    // Forward the completing write into a read of the same word accepted on that edge.
    assign ram_acc   = mem[acc_idx];
    assign fwd       = wr_commit & (dp_idx == acc_idx);
    assign acc_word  = fwd ? ((ram_acc & ~wr_bits) | (bus.HWDATA & wr_bits)) : ram_acc;

    // State register.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_ERR2: begin
                if (accept) begin
                    if (acc_err)              state_nxt = S_ERR1;
                    else if (WAIT_STATES > 0) state_nxt = S_WAIT;
                    else                      state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT:  state_nxt = (cnt <= 4'd1) ? S_IDLE : S_WAIT;
            S_ERR1:  state_nxt = S_ERR2;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Response outputs decoded from state.
    always_comb begin
        ready_o = 1'b1;
        resp_o  = 1'b0;
        case (state)
            S_WAIT:  begin ready_o = 1'b0; resp_o = 1'b0; end
            S_ERR1:  begin ready_o = 1'b0; resp_o = 1'b1; end
            S_ERR2:  begin ready_o = 1'b1; resp_o = 1'b1; end
            default: begin ready_o = 1'b1; resp_o = 1'b0; end
        endcase
    end

    assign bus.HREADYOUT = ready_o;
    assign bus.HRESP     = resp_o;
    assign bus.HRDATA    = rdata_q;

    // Latch the accepted transfer and run the wait counter.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            cnt      <= '0;
            dp_vld   <= 1'b0;
            dp_write <= 1'b0;
            dp_idx   <= '0;
            dp_mask  <= '0;
        end else if (accept) begin
            dp_vld   <= ~acc_err;
            dp_write <= bus.HWRITE;
            dp_idx   <= acc_idx;
            dp_mask  <= acc_mask;
            cnt      <= acc_err ? 4'd0 : 4'(WAIT_STATES);
        end else if (state == S_WAIT) begin
            cnt <= cnt - 4'd1;
        end else if (ready_o) begin
            dp_vld <= 1'b0;
        end
    end

    // Read data register: loaded on accept, refreshed during WAIT, zero otherwise.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            rdata_q <= '0;
        end else if (accept) begin
            rdata_q <= load_rd ? (acc_word & bit_mask(acc_mask)) : '0;
        end else if (state == S_WAIT && dp_vld && !dp_write) begin
            rdata_q <= mem[dp_idx] & wr_bits;
        end else if (ready_o) begin
            rdata_q <= '0;
        end
    end

    // RAM write port, lane-masked; contents survive reset.
    always_ff @(posedge HCLK) begin
        if (HRESETn && wr_commit) begin
            for (int i = 0; i < NB; i++)
                if (dp_mask[i]) mem[dp_idx][8*i +: 8] <= bus.HWDATA[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_adbg_ahb3_slave.sv
// Bench: table-driven vectors on a zero-wait instance, hand sequences on a
// three-wait instance for wait timing, pipelined accept and mid-WAIT reset.
module tb_adbg_ahb3_slave;
    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NS = 2'b10;

    logic clk;
    logic rst0_n, rst3_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    adbg_ahb3_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if0 ();
    adbg_ahb3_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if3 ();

    assign if0.HREADY = if0.HREADYOUT;
    assign if3.HREADY = if3.HREADYOUT;

    adbg_ahb3_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0))
        u_dut0 (.HCLK(clk), .HRESETn(rst0_n), .bus(if0));
    adbg_ahb3_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(3))
        u_dut3 (.HCLK(clk), .HRESETn(rst3_n), .bus(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic [1:0]  tr;
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        rdy;
        logic        resp;
        logic [31:0] rd;
    } vec_t;

    vec_t tv [29];

    function automatic vec_t v(input logic s, input logic [1:0] t, input logic w, input logic [2:0] z,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic r, input logic e, input logic [31:0] q);
        vec_t x;
        x.sel = s; x.tr = t; x.wr = w; x.sz = z; x.addr = a; x.wd = d;
        x.rdy = r; x.resp = e; x.rd = q;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drv(input bit d3, input logic s, input logic [1:0] t, input logic w,
                       input logic [2:0] z, input logic [31:0] a, input logic [31:0] d);
        if (d3) begin
            if3.HSEL = s; if3.HTRANS = t; if3.HWRITE = w; if3.HSIZE = z; if3.HADDR = a; if3.HWDATA = d;
        end else begin
            if0.HSEL = s; if0.HTRANS = t; if0.HWRITE = w; if0.HSIZE = z; if0.HADDR = a; if0.HWDATA = d;
        end
    endtask

    // Check the three-wait instance mid-cycle, then advance to just after the next edge.
    task automatic cyc3(input string nm, input logic r, input logic e, input logic [31:0] q);
        @(negedge clk);
        chk({nm, " rdy"},   32'(if3.HREADYOUT), 32'(r));
        chk({nm, " resp"},  32'(if3.HRESP),     32'(e));
        chk({nm, " rdata"}, if3.HRDATA,          q);
        @(posedge clk); #1;
    endtask

    initial begin
        // Zero-wait instance: address phase of row k, write data for row k-1,
        // expected outputs are the data phase of row k-1.
        tv[0]  = v(1, T_NS,   1, 2, 32'h00,  32'h0,        1, 0, 32'h0);
        tv[1]  = v(1, T_NS,   1, 2, 32'h10,  32'h12345678, 1, 0, 32'h0);
        tv[2]  = v(1, T_NS,   0, 2, 32'h10,  32'hDEADBEEF, 1, 0, 32'h0);
        tv[3]  = v(1, T_NS,   1, 2, 32'h20,  32'h0,        1, 0, 32'hDEADBEEF);
        tv[4]  = v(1, T_NS,   1, 0, 32'h21,  32'h0,        1, 0, 32'h0);
        tv[5]  = v(1, T_NS,   1, 1, 32'h22,  32'h0000AA00, 1, 0, 32'h0);
        tv[6]  = v(1, T_NS,   0, 2, 32'h20,  32'h55660000, 1, 0, 32'h0);
        tv[7]  = v(1, T_IDLE, 0, 2, 32'h0,   32'h0,        1, 0, 32'h5566AA00);
        tv[8]  = v(1, T_NS,   0, 2, 32'h10,  32'h0,        1, 0, 32'h0);
        tv[9]  = v(1, T_IDLE, 0, 2, 32'h0,   32'h0,        1, 0, 32'hDEADBEEF);
        tv[10] = v(1, T_NS,   0, 0, 32'h13,  32'h0,        1, 0, 32'h0);
        tv[11] = v(1, T_IDLE, 0, 2, 32'h0,   32'h0,        1, 0, 32'hDE000000);
        tv[12] = v(1, T_NS,   0, 2, 32'h400, 32'h0,        1, 0, 32'h0);
        tv[13] = v(1, T_IDLE, 0, 2, 32'h0,   32'h0,        0, 1, 32'h0);
        tv[14] = v(1, T_NS,   0, 2, 32'h02,  32'h0,        1, 1, 32'h0);
        tv[15] = v(1, T_IDLE, 0, 2, 32'h0,   32'h0,        0, 1, 32'h0);
        tv[16] = v(1, T_NS,   1, 2, 32'h02,  32'h0,        1, 1, 32'h0);
        tv[17] = v(1, T_IDLE, 0, 2, 32'h0,   32'hFFFFFFFF, 0, 1, 32'h0);
        tv[18] = v(1, T_NS,   0, 3, 32'h20,  32'hFFFFFFFF, 1, 1, 32'h0);
        tv[19] = v(1, T_IDLE, 0, 2, 32'h0,   32'h0,        0, 1, 32'h0);
        tv[20] = v(1, T_NS,   0, 2, 32'h00,  32'h0,        1, 1, 32'h0);
        tv[21] = v(1, T_IDLE, 0, 2, 32'h0,   32'h0,        1, 0, 32'h12345678);
        tv[22] = v(0, T_NS,   1, 2, 32'h00,  32'h0,        1, 0, 32'h0);
        tv[23] = v(1, T_BUSY, 1, 2, 32'h00,  32'hFFFFFFFF, 1, 0, 32'h0);
        tv[24] = v(1, T_IDLE, 1, 2, 32'h00,  32'hFFFFFFFF, 1, 0, 32'h0);
        tv[25] = v(1, T_NS,   0, 2, 32'h00,  32'h0,        1, 0, 32'h0);
        tv[26] = v(1, T_IDLE, 0, 2, 32'h0,   32'h0,        1, 0, 32'h12345678);
        tv[27] = v(1, T_NS,   0, 1, 32'h12,  32'h0,        1, 0, 32'h0);
        tv[28] = v(1, T_IDLE, 0, 2, 32'h0,   32'h0,        1, 0, 32'hDEAD0000);

        if0.HBURST = 3'd0; if0.HPROT = 4'd3; if0.HMASTLOCK = 1'b0;
        if3.HBURST = 3'd0; if3.HPROT = 4'd3; if3.HMASTLOCK = 1'b0;
        drv(0, 0, T_IDLE, 0, 3'd2, 32'h0, 32'h0);
        drv(1, 0, T_IDLE, 0, 3'd2, 32'h0, 32'h0);
        rst0_n = 1'b0;
        rst3_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset0 rdy",   32'(if0.HREADYOUT), 32'd1);
        chk("reset0 resp",  32'(if0.HRESP),     32'd0);
        chk("reset0 rdata", if0.HRDATA,          32'h0);
        chk("reset3 rdy",   32'(if3.HREADYOUT), 32'd1);
        chk("reset3 rdata", if3.HRDATA,          32'h0);
        rst0_n = 1'b1;
        rst3_n = 1'b1;

        for (int i = 0; i < 29; i++) begin
            drv(0, tv[i].sel, tv[i].tr, tv[i].wr, tv[i].sz, tv[i].addr, tv[i].wd);
            @(negedge clk);
            chk($sformatf("row%0d rdy", i),   32'(if0.HREADYOUT), 32'(tv[i].rdy));
            chk($sformatf("row%0d resp", i),  32'(if0.HRESP),     32'(tv[i].resp));
            chk($sformatf("row%0d rdata", i), if0.HRDATA,          tv[i].rd);
            @(posedge clk); #1;
        end
        drv(0, 0, T_IDLE, 0, 3'd2, 32'h0, 32'h0);

        // Three waits: write 0x04, read it back, next NONSEQ held through the waits.
        drv(1, 1, T_NS,   1, 3'd2, 32'h04,  32'h0);        cyc3("w3 wr acc", 1, 0, 32'h0);
        drv(1, 1, T_IDLE, 0, 3'd2, 32'h0,   32'hCAFEF00D);  cyc3("w3 wr w1", 0, 0, 32'h0);
        cyc3("w3 wr w2", 0, 0, 32'h0);
        cyc3("w3 wr w3", 0, 0, 32'h0);
        drv(1, 1, T_NS,   0, 3'd2, 32'h04,  32'hCAFEF00D);  cyc3("w3 wr rdy", 1, 0, 32'h0);
        drv(1, 1, T_NS,   0, 3'd2, 32'h400, 32'h0);         cyc3("w3 rd w1", 0, 0, 32'hCAFEF00D);
        drv(1, 1, T_NS,   1, 3'd2, 32'h08,  32'h0);         cyc3("w3 rd w2", 0, 0, 32'hCAFEF00D);
        cyc3("w3 rd w3", 0, 0, 32'hCAFEF00D);
        cyc3("w3 rd rdy", 1, 0, 32'hCAFEF00D);
        drv(1, 1, T_IDLE, 0, 3'd2, 32'h0,   32'h11223344);  cyc3("w3 pipe w1", 0, 0, 32'h0);
        cyc3("w3 pipe w2", 0, 0, 32'h0);
        cyc3("w3 pipe w3", 0, 0, 32'h0);
        drv(1, 1, T_NS,   0, 3'd2, 32'h08,  32'h11223344);  cyc3("w3 pipe rdy", 1, 0, 32'h0);
        drv(1, 1, T_IDLE, 0, 3'd2, 32'h0,   32'h0);         cyc3("w3 rd8 w1", 0, 0, 32'h11223344);
        cyc3("w3 rd8 w2", 0, 0, 32'h11223344);
        cyc3("w3 rd8 w3", 0, 0, 32'h11223344);
        cyc3("w3 rd8 rdy", 1, 0, 32'h11223344);
        cyc3("w3 idle", 1, 0, 32'h0);

        // Reset during the second wait cycle of a write to 0x08.
        drv(1, 1, T_NS,   1, 3'd2, 32'h08,  32'h0);         cyc3("rst acc", 1, 0, 32'h0);
        drv(1, 1, T_IDLE, 0, 3'd2, 32'h0,   32'h99999999);  cyc3("rst w1", 0, 0, 32'h0);
        rst3_n = 1'b0;                                       cyc3("rst w2", 0, 0, 32'h0);
        rst3_n = 1'b1;
        drv(1, 1, T_NS,   0, 3'd2, 32'h08,  32'h0);         cyc3("rst clean", 1, 0, 32'h0);
        drv(1, 1, T_IDLE, 0, 3'd2, 32'h0,   32'h0);         cyc3("rst rd w1", 0, 0, 32'h11223344);
        cyc3("rst rd w2", 0, 0, 32'h11223344);
        cyc3("rst rd w3", 0, 0, 32'h11223344);
        cyc3("rst rd rdy", 1, 0, 32'h11223344);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
